// File: rtl/cache_mem_arbiter.sv
// Single-ported RAM arbiter between the icache miss path and the dcache fill/writeback path.
// Data side has priority; a starvation counter forces an instruction grant.
module cache_mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] next_starve_cnt;
    logic             d_req;
    logic             i_starved;

    assign d_req     = dREN | dWEN;
    assign i_starved = iREN && (starve_cnt >= STARVE_LIM);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= next_state;
            starve_cnt <= next_starve_cnt;
        end
    end

    // NOTE: every output and next-state signal gets a default first so no path infers a latch.
    always_comb begin
        next_state      = state;
        next_starve_cnt = starve_cnt;
        iwait           = 1'b1;
        dwait           = 1'b1;
        iload           = '0;
        dload           = '0;
        ramREN          = 1'b0;
        ramWEN          = 1'b0;
        ramaddr         = '0;
        ramstore        = '0;

        case (state)
            IDLE: begin
                if (d_req && !i_starved) begin
                    next_state = DGRANT;
                end else if (iREN) begin
                    next_state = IGRANT;
                end
            end

            DGRANT: begin
                if (!d_req) begin
                    // Withdrawn request: release the RAM without completing.
                    next_state = IDLE;
                end else begin
                    ramaddr = daddr;
                    if (dWEN) begin
                        ramWEN   = 1'b1;
                        ramstore = dstore;
                    end else begin
                        ramREN = 1'b1;
                    end
                    if (ram_ready) begin
                        dwait      = 1'b0;
                        next_state = IDLE;
                        if (!dWEN) begin
                            dload = ramload;
                        end
                        if (iREN && (starve_cnt < STARVE_LIM)) begin
                            next_starve_cnt = starve_cnt + CNT_W'(1);
                        end
                    end
                end
            end

            IGRANT: begin
                if (!iREN) begin
                    next_state = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ram_ready) begin
                        iwait           = 1'b0;
                        iload           = ramload;
                        next_state      = IDLE;
                        next_starve_cnt = '0;
                    end
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: bus-ownership model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_cache_mem_arbiter;

    localparam int STARVE_MAX = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ram_ready;

    cache_mem_arbiter #(.STARVE_MAX(STARVE_MAX), .CNT_W(4)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .iwait     (iwait),
        .iload     (iload),
        .dREN      (dREN),
        .dWEN      (dWEN),
        .daddr     (daddr),
        .dstore    (dstore),
        .dwait     (dwait),
        .dload     (dload),
        .ramREN    (ramREN),
        .ramWEN    (ramWEN),
        .ramaddr   (ramaddr),
        .ramstore  (ramstore),
        .ramload   (ramload),
        .ram_ready (ram_ready)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: who currently owns the RAM, and how many data transactions finished
    // while the instruction side was kept waiting.
    typedef enum int {OWN_NONE, OWN_INSTR, OWN_DATA} owner_t;
    owner_t owner;
    int     starve;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            owner  <= OWN_NONE;
            starve <= 0;
        end else begin
            case (owner)
                OWN_NONE: begin
                    if ((dREN || dWEN) && !(iREN && starve >= STARVE_MAX)) owner <= OWN_DATA;
                    else if (iREN) owner <= OWN_INSTR;
                end
                OWN_DATA: begin
                    if (!(dREN || dWEN)) owner <= OWN_NONE;
                    else if (ram_ready) begin
                        owner <= OWN_NONE;
                        if (iREN) starve <= (starve + 1 > STARVE_MAX) ? STARVE_MAX : starve + 1;
                    end
                end
                default: begin
                    if (!iREN) owner <= OWN_NONE;
                    else if (ram_ready) begin
                        owner  <= OWN_NONE;
                        starve <= 0;
                    end
                end
            endcase
        end
    end

    logic        e_iwait, e_dwait, e_ramREN, e_ramWEN;
    logic [31:0] e_iload, e_dload, e_ramaddr, e_ramstore;

    always_comb begin
        e_iwait    = 1'b1;
        e_dwait    = 1'b1;
        e_iload    = '0;
        e_dload    = '0;
        e_ramREN   = 1'b0;
        e_ramWEN   = 1'b0;
        e_ramaddr  = '0;
        e_ramstore = '0;
        if (owner == OWN_DATA && (dREN || dWEN)) begin
            e_ramaddr  = daddr;
            e_ramWEN   = dWEN;
            e_ramREN   = !dWEN;
            e_ramstore = dWEN ? dstore : 32'h0;
            if (ram_ready) begin
                e_dwait = 1'b0;
                e_dload = dWEN ? 32'h0 : ramload;
            end
        end else if (owner == OWN_INSTR && iREN) begin
            e_ramREN  = 1'b1;
            e_ramaddr = iaddr;
            if (ram_ready) begin
                e_iwait = 1'b0;
                e_iload = ramload;
            end
        end
    end

    always @(negedge CLK) begin
        if (cmp_en) begin
            check("m_iwait",    {31'b0, iwait},  {31'b0, e_iwait});
            check("m_dwait",    {31'b0, dwait},  {31'b0, e_dwait});
            check("m_iload",    iload,           e_iload);
            check("m_dload",    dload,           e_dload);
            check("m_ramREN",   {31'b0, ramREN}, {31'b0, e_ramREN});
            check("m_ramWEN",   {31'b0, ramWEN}, {31'b0, e_ramWEN});
            check("m_ramaddr",  ramaddr,         e_ramaddr);
            check("m_ramstore", ramstore,        e_ramstore);
        end
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_ramREN"}, {31'b0, ramREN}, 32'd0);
        check({tag, "_ramWEN"}, {31'b0, ramWEN}, 32'd0);
        check({tag, "_iwait"},  {31'b0, iwait},  32'd1);
        check({tag, "_dwait"},  {31'b0, dwait},  32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    int          ren_cycles;
    logic [11:0] exp_d;
    logic [11:0] exp_i;

    initial begin
        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ram_ready = 1'b0;
        cmp_en = 1'b1;

        // Reset holds every output idle even with requests present.
        #2;
        iREN = 1'b1; dWEN = 1'b1; ram_ready = 1'b1;
        daddr = 32'h10; dstore = 32'h99; ramload = 32'h77;
        #1;
        expect_idle("rst");
        check("rst_iload",    iload,    32'h0);
        check("rst_dload",    dload,    32'h0);
        check("rst_ramaddr",  ramaddr,  32'h0);
        check("rst_ramstore", ramstore, 32'h0);
        next_cycle();
        next_cycle();
        iREN = 1'b0; dWEN = 1'b0; ram_ready = 1'b0; ramload = '0;
        nRST = 1'b1;

        // Instruction read, RAM ready on the third grant cycle.
        next_cycle();
        iREN = 1'b1; iaddr = 32'h40;
        #2 expect_idle("i_idle");
        ren_cycles = 0;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            ram_ready = (k == 2);
            ramload   = (k == 2) ? 32'hDEADBEEF : 32'h0;
            #2;
            if (ramREN) ren_cycles++;
            check("i_iwait", {31'b0, iwait}, (k == 2) ? 32'd0 : 32'd1);
            check("i_ramaddr", ramaddr, 32'h40);
        end
        check("i_iload", iload, 32'hDEADBEEF);
        next_cycle();
        iREN = 1'b0; ram_ready = 1'b0; ramload = '0;
        #2;
        if (ramREN) ren_cycles++;
        expect_idle("i_after");
        check("i_ramren_cycles", ren_cycles, 32'd3);

        // Simultaneous requests: data first, bubble, then instruction.
        next_cycle();
        iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h200;
        #2 expect_idle("both_idle");
        next_cycle();
        ram_ready = 1'b1; ramload = 32'h55;
        #2;
        check("both_d_addr",  ramaddr,           32'h200);
        check("both_d_dwait", {31'b0, dwait},    32'd0);
        check("both_d_dload", dload,             32'h55);
        check("both_d_iwait", {31'b0, iwait},    32'd1);
        next_cycle();
        dREN = 1'b0; ram_ready = 1'b0;
        #2 expect_idle("both_bubble");
        next_cycle();
        ram_ready = 1'b1; ramload = 32'h66;
        #2;
        check("both_i_addr",  ramaddr,        32'h80);
        check("both_i_iwait", {31'b0, iwait}, 32'd0);
        check("both_i_iload", iload,          32'h66);
        check("both_i_dwait", {31'b0, dwait}, 32'd1);
        next_cycle();
        iREN = 1'b0; ram_ready = 1'b0;
        #2 expect_idle("both_after");

        // Continuous writes with a pending instruction read: 4 writes, then forced IGRANT.
        exp_d = 12'b1000_1010_1010;
        exp_i = 12'b0010_0000_0000;
        next_cycle();
        dWEN = 1'b1; iREN = 1'b1; daddr = 32'h300; dstore = 32'hCAFE;
        iaddr = 32'h400; ram_ready = 1'b1; ramload = 32'h1111;
        for (int c = 0; c < 12; c++) begin
            if (c != 0) next_cycle();
            #2;
            check("starve_dwait", {31'b0, dwait}, {31'b0, !exp_d[c]});
            check("starve_iwait", {31'b0, iwait}, {31'b0, !exp_i[c]});
        end
        next_cycle();
        dWEN = 1'b0; iREN = 1'b0; ram_ready = 1'b0; ramload = '0;
        #2 expect_idle("starve_after");

        // Read and write together: write wins.
        next_cycle();
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h100; dstore = 32'h1234;
        #2 expect_idle("rw_idle");
        next_cycle();
        #2;
        check("rw_ramWEN",   {31'b0, ramWEN}, 32'd1);
        check("rw_ramREN",   {31'b0, ramREN}, 32'd0);
        check("rw_ramstore", ramstore,        32'h1234);
        check("rw_ramaddr",  ramaddr,         32'h100);
        check("rw_dwait",    {31'b0, dwait},  32'd1);
        next_cycle();
        ram_ready = 1'b1; ramload = 32'hAAAA;
        #2;
        check("rw_done_dwait", {31'b0, dwait}, 32'd0);
        check("rw_done_dload", dload,          32'h0);
        next_cycle();
        dREN = 1'b0; dWEN = 1'b0; ram_ready = 1'b0; ramload = '0;
        #2 expect_idle("rw_after");

        // Data read withdrawn mid-grant; ram_ready ignored in the following IDLE.
        next_cycle();
        dREN = 1'b1; daddr = 32'h300;
        #2 expect_idle("wd_idle");
        next_cycle();
        #2;
        check("wd_ramREN",  {31'b0, ramREN}, 32'd1);
        check("wd_ramaddr", ramaddr,         32'h300);
        next_cycle();
        dREN = 1'b0;
        #2 expect_idle("wd_drop");
        next_cycle();
        dREN = 1'b1; ram_ready = 1'b1; ramload = 32'hBBBB;
        #2 expect_idle("wd_reidle");
        next_cycle();
        #2;
        check("wd_ramREN2", {31'b0, ramREN}, 32'd1);
        check("wd_dwait",   {31'b0, dwait},  32'd0);
        check("wd_dload",   dload,           32'hBBBB);
        next_cycle();
        dREN = 1'b0; ram_ready = 1'b0; ramload = '0;
        #2 expect_idle("wd_after");

        // Reset in the middle of a write aborts it immediately.
        next_cycle();
        dWEN = 1'b1; daddr = 32'h500; dstore = 32'h5555;
        #2 expect_idle("mr_idle");
        next_cycle();
        #2;
        check("mr_ramWEN", {31'b0, ramWEN}, 32'd1);
        nRST = 1'b0;
        #1;
        expect_idle("mr_rst");
        check("mr_ramaddr",  ramaddr,  32'h0);
        check("mr_ramstore", ramstore, 32'h0);
        next_cycle();
        nRST = 1'b1; ram_ready = 1'b1;
        #2 expect_idle("mr_release");
        next_cycle();
        #2;
        check("mr_regrant_ramWEN", {31'b0, ramWEN}, 32'd1);
        check("mr_regrant_dwait",  {31'b0, dwait},  32'd0);
        next_cycle();
        dWEN = 1'b0; ram_ready = 1'b0;
        #2 expect_idle("mr_after");

        next_cycle();
        next_cycle();
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
